// File: rtl/vliw_bundle_fetch.sv
// VLIW fetch front end: parses 16/32-bit parcels and terminators from a 48-bit IMEM window,
// packs up to three instructions per bundle and offers it to decode over valid/ready.
module vliw_bundle_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [4:0]  flush_pc,
  input  logic [47:0] IR,
  input  logic        bundle_ready,
  output logic [4:0]  pc_5bits,
  output logic        bundle_valid,
  output logic [31:0] bundle_slot0,
  output logic [31:0] bundle_slot1,
  output logic [31:0] bundle_slot2,
  output logic [2:0]  bundle_mask,
  output logic [2:0]  bundle_c,
  output logic [4:0]  bundle_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [31:0] slot0_q, slot0_d;
  logic [31:0] slot1_q, slot1_d;
  logic [31:0] slot2_q, slot2_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  c_q, c_d;
  logic [4:0]  bpc_q, bpc_d;
  logic        err_q, err_d;

  logic [15:0] p0;
  logic        is_term;
  logic        is_32;
  logic [31:0] insn;

  assign p0      = IR[15:0];
  assign is_term = (p0 == 16'h0000);
  assign is_32   = (p0[1:0] == 2'b11);
  assign insn    = is_32 ? IR[31:0] : {16'h0000, p0};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    mask_d  = mask_q;
    c_d     = c_q;
    bpc_d   = bpc_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (is_term) begin
          pc_d = pc_q + 5'd1;
          if (mask_q != 3'b000) state_d = S_EMIT;
        end else if (is_32 && (pc_q == 5'd31)) begin
          // A 32-bit instruction cannot straddle the top of memory; drop the partial bundle.
          state_d = S_HALT;
          err_d   = 1'b1;
          slot0_d = '0;
          slot1_d = '0;
          slot2_d = '0;
          mask_d  = '0;
          c_d     = '0;
          bpc_d   = '0;
        end else begin
          pc_d   = pc_q + (is_32 ? 5'd2 : 5'd1);
          mask_d = {mask_q[1:0], 1'b1};
          if (mask_q == 3'b000) begin
            slot0_d = insn;
            c_d[0]  = ~is_32;
            bpc_d   = pc_q;
          end else if (mask_q == 3'b001) begin
            slot1_d = insn;
            c_d[1]  = ~is_32;
          end else begin
            slot2_d = insn;
            c_d[2]  = ~is_32;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (bundle_ready) begin
          state_d = S_FETCH;
          slot0_d = '0;
          slot1_d = '0;
          slot2_d = '0;
          mask_d  = '0;
          c_d     = '0;
          bpc_d   = '0;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything; a coinciding transfer has already been seen by decode.
    if (flush) begin
      state_d = S_FETCH;
      pc_d    = flush_pc;
      slot0_d = '0;
      slot1_d = '0;
      slot2_d = '0;
      mask_d  = '0;
      c_d     = '0;
      bpc_d   = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      slot2_q <= '0;
      mask_q  <= '0;
      c_q     <= '0;
      bpc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      mask_q  <= mask_d;
      c_q     <= c_d;
      bpc_q   <= bpc_d;
      err_q   <= err_d;
    end
  end

  assign pc_5bits     = pc_q;
  assign bundle_valid = (state_q == S_EMIT);
  assign bundle_slot0 = slot0_q;
  assign bundle_slot1 = slot1_q;
  assign bundle_slot2 = slot2_q;
  assign bundle_mask  = mask_q;
  assign bundle_c     = c_q;
  assign bundle_pc    = bpc_q;
  assign fetch_err    = err_q;

endmodule
